l1_dcache_wb: RTL
=================

Name: l1_dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and the synchronous single-port D-memory.
- Serves loads and stores from the MEM pipeline register in the same cycle on a hit.
- On a miss, raises freeze, which stalls every pipeline latch and the PC, while it performs writeback and refill.
- Exposes hit and miss counters for the test harness.

Parameters:
- NUM_LINES, 8, number of cache lines (power of 2); index = addr[6:4] at default.
- WORDS_PER_LINE, 4, 32-bit words per line (power of 2); word offset = addr[3:2] at default.
- CNT_W, 16, width of the saturating hit and miss counters.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous reset, active-low.
- req_rd  in  1  load request from MEM stage.
- req_wr  in  1  store request from MEM stage.
- req_addr  in  12  byte address; bits [1:0] ignored.
- req_wdata  in  32  store data.
- req_be  in  4  store byte enables.
- rdata  out  32  load data; valid in the cycle freeze=0 with req_rd=1.
- freeze  out  1  stall the whole pipeline.
- mem_addr  out  12  D-memory byte address, word aligned ([1:0]=0).
- mem_wen  out  1  D-memory write enable, active-low.
- mem_be  out  4  D-memory byte enables (always 4'b1111).
- mem_dout  out  32  write data to D-memory.
- mem_din  in  32  read data from D-memory, valid one cycle after the address is presented.
- hit_cnt  out  CNT_W  saturating hit count.
- miss_cnt  out  CNT_W  saturating miss count.

Behaviour:
- Address split (defaults):
  - tag = addr[11:7] (5 bits), index = addr[6:4], offset = addr[3:2].
  - Each line stores valid, dirty, tag and WORDS_PER_LINE data words.
- Reset (RSTn=0 at posedge):
  - All valid and dirty bits cleared; state = IDLE.
  - Counters = 0.
  - Outputs: freeze=0, mem_wen=1, mem_addr=0, mem_dout=0, rdata=0.
  - Reset mid-writeback or mid-refill abandons the operation; a partially written memory line is acceptable.
- State machine: IDLE, WRITEBACK, REFILL.
- IDLE:
  - With req_rd|req_wr and no hit (invalid or tag mismatch), freeze=1 combinationally in the same cycle.
  - Next state is WRITEBACK if the victim is valid and dirty, otherwise REFILL.
  - miss_cnt increments once at this edge.
- Hit in IDLE:
  - freeze=0.
  - Read: rdata = line word, combinational.
  - Write: the selected bytes are updated at the posedge and dirty is set.
  - hit_cnt increments once per hit cycle.
- Counters saturate at all-ones; no wrap.
- Re-lookup after a miss: when the FSM returns to IDLE the request is looked up again and hits. That hit cycle counts in hit_cnt; the miss is counted once only.
- WRITEBACK:
  - WORDS_PER_LINE cycles, with freeze=1 throughout.
  - Cycle k drives mem_wen=0, mem_addr={victim tag, index, k, 2'b00}, mem_dout=word k.
  - After the last word, the dirty bit is cleared and the FSM goes to REFILL.
- REFILL:
  - WORDS_PER_LINE+1 cycles, with freeze=1 and mem_wen=1.
  - Cycle k < WORDS_PER_LINE drives mem_addr={req tag, index, k, 2'b00}.
  - mem_din captured in cycle k+1 is written into word k.
  - In the final cycle the tag is written, valid=1, dirty=0, and the FSM goes to IDLE.
- Miss latencies at default:
  - Clean miss: freeze high for exactly 5 cycles, then a 1-cycle hit.
  - Dirty miss: freeze high for exactly 9 cycles, then a 1-cycle hit.
- Write allocate: a store miss refills first, then merges the store on the hit cycle.
- Simultaneous req_rd and req_wr: treated as a store; rdata is don't-care.
- Request inputs must stay stable while freeze=1. If the request drops mid-miss, the fill still completes and no access is performed.
- Idle cycle (no request): freeze=0, mem_wen=1, and no state change.
- Outside WRITEBACK, mem_wen=1.

Test Plan:
- Cold read 0x104 after reset, memory word 0x104=0xDEADBEEF → freeze high 5 cycles; mem_addr steps 0x100,0x104,0x108,0x10C; rdata=0xDEADBEEF on the 6th cycle; miss_cnt=1, hit_cnt=1.
- Read 0x108 immediately after → freeze=0 in the same cycle, no memory access, hit_cnt=2.
- Store 0x11223344 with be=4'b0011 to 0x104 (hit), then load 0x104 → 0xDEAD3344; no mem_wen=0 cycles occur.
- Read 0x184 (same index 0, different tag) with line 0 dirty → 4 write cycles to 0x100-0x10C with word 1=0xDEAD3344, then refill from 0x180; freeze 9 cycles; miss_cnt=2.
- Assert RSTn=0 in the 3rd refill cycle, release, re-read 0x104 → full 5-cycle miss again (valid cleared), counters restart at 0.
- Force hit_cnt to all-ones by 65 535 hits plus extra hits → stays 0xFFFF; miss_cnt is unaffected.

Source files
------------

// File: rtl/l1_dcache_wb.sv
// l1_dcache_wb: direct-mapped, write-back, write-allocate L1 data cache with miss freeze.
// Serves hits in the same cycle; on a miss it freezes the pipeline for writeback and refill.
`default_nettype none
`timescale 1ns/1ps

module l1_dcache_wb #(
  parameter int NUM_LINES      = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             req_rd,
  input  logic             req_wr,
  input  logic [11:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [3:0]       req_be,
  output logic [31:0]      rdata,
  output logic             freeze,
  output logic [11:0]      mem_addr,
  output logic             mem_wen,
  output logic [3:0]       mem_be,
  output logic [31:0]      mem_dout,
  input  logic [31:0]      mem_din,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 10 - OFF_W - IDX_W;
  localparam int CW    = OFF_W + 1;
  localparam logic [CW-1:0]    CNT_LAST    = CW'(WORDS_PER_LINE);
  localparam logic [CW-1:0]    CNT_WB_LAST = CW'(WORDS_PER_LINE - 1);
  localparam logic [OFF_W-1:0] OFF0        = '0;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [NUM_LINES-1:0]   valid;
  logic [NUM_LINES-1:0]   dirty;
  logic [TAG_W-1:0]       tags [NUM_LINES];
  logic [31:0]            data [NUM_LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]       miss_tag;
  logic [IDX_W-1:0]       miss_idx;

  logic [TAG_W-1:0]       req_tag;
  logic [IDX_W-1:0]       req_idx;
  logic [OFF_W-1:0]       req_off;
  logic                   req;
  logic                   hit;
  logic                   victim_dirty;
  logic [CW-1:0]          cnt_m1;

  assign req_tag      = req_addr[11 -: TAG_W];
  assign req_idx      = req_addr[2+OFF_W +: IDX_W];
  assign req_off      = req_addr[2 +: OFF_W];
  assign req          = req_rd | req_wr;
  assign hit          = (state == IDLE) && req && valid[req_idx] && (tags[req_idx] == req_tag);
  assign victim_dirty = valid[req_idx] & dirty[req_idx];
  assign cnt_m1       = cnt - 1'b1;
  assign freeze       = (state != IDLE) || (req && !hit);
  assign rdata        = (hit && req_rd) ? data[{req_idx, req_off}] : 32'd0;
  assign mem_be       = 4'b1111;

  wire unused = &{1'b0, req_addr[1:0], cnt_m1[CW-1]};

  // The miss-detect cycle already issues the first memory beat (writeback word 0 or refill word 0).
  always_comb begin
    mem_wen  = 1'b1;
    mem_addr = 12'd0;
    mem_dout = 32'd0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          if (victim_dirty) begin
            mem_wen  = 1'b0;
            mem_addr = {tags[req_idx], req_idx, OFF0, 2'b00};
            mem_dout = data[{req_idx, OFF0}];
          end else begin
            mem_addr = {req_tag, req_idx, OFF0, 2'b00};
          end
        end
      end
      WRITEBACK: begin
        mem_wen  = 1'b0;
        mem_addr = {tags[miss_idx], miss_idx, cnt[OFF_W-1:0], 2'b00};
        mem_dout = data[{miss_idx, cnt[OFF_W-1:0]}];
      end
      REFILL: begin
        mem_addr = {miss_tag, miss_idx, cnt[OFF_W-1:0], 2'b00};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state    <= IDLE;
      cnt      <= '0;
      valid    <= '0;
      dirty    <= '0;
      miss_tag <= '0;
      miss_idx <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
            if (req_wr) begin
              for (int b = 0; b < 4; b++)
                if (req_be[b]) data[{req_idx, req_off}][8*b +: 8] <= req_wdata[8*b +: 8];
              dirty[req_idx] <= 1'b1;
            end
          end else if (req) begin
            if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            cnt      <= CW'(1);
            state    <= victim_dirty ? WRITEBACK : REFILL;
          end
        end
        WRITEBACK: begin
          if (cnt == CNT_WB_LAST) begin
            dirty[miss_idx] <= 1'b0;
            cnt             <= '0;
            state           <= REFILL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REFILL: begin
          // mem_din holds the word addressed in the previous cycle.
          if (cnt != '0) data[{miss_idx, cnt_m1[OFF_W-1:0]}] <= mem_din;
          if (cnt == CNT_LAST) begin
            tags[miss_idx]  <= miss_tag;
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            cnt             <= '0;
            state           <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
